// File: rtl/laser_pkg.sv
// Shared types and constants for the laser tower: coord slicing, screen size,
// scan/draw state encodings and a small abs helper.
package laser_pkg;
  localparam int COORD_W  = 15;
  localparam int COLOUR_W = 9;
  localparam int X_MSB    = 14;
  localparam int X_LSB    = 7;
  localparam int Y_MSB    = 6;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_FIRE} scan_state_e;
  typedef enum logic [1:0] {D_IDLE, D_DRAW, D_DONE} draw_state_e;

  function automatic logic [8:0] abs9(input logic signed [8:0] v);
    return v[8] ? 9'(-v) : 9'(v);
  endfunction
endpackage

// File: rtl/laser_tower_if.sv
// Draw handshake shared with the car bank: start pulse in, pixel writes and done pulse out.
interface laser_tower_if;
  import laser_pkg::*;
  logic                enable_draw;
  logic                draw_done;
  logic                vga_WriteEn;
  logic [COORD_W-1:0]  vga_coords;
  logic [COLOUR_W-1:0] vga_colour;

  modport master (input enable_draw, output draw_done, vga_WriteEn, vga_coords, vga_colour);
  modport slave  (output enable_draw, input draw_done, vga_WriteEn, vga_coords, vga_colour);
endinterface

// File: rtl/laser_flash_draw.sv
// 3x3 laser-flash sprite drawer: draw FSM, row/col counter, screen clipping and
// registered VGA outputs. Only instantiated when LASER_TOWER_FLASH_EN is defined.
module laser_flash_draw
  import laser_pkg::*;
#(
  parameter logic [COLOUR_W-1:0] FLASH_COLOUR = 9'h1C0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flash_pending,
  input  logic [COORD_W-1:0] centre,
  laser_tower_if.master      vga
);
  draw_state_e st_q, st_d;
  logic [1:0]  col_q, col_d, row_q, row_d;
  logic        en_q, rise;
  logic [8:0]  px, py;
  logic        on;

  assign rise = vga.enable_draw & ~en_q;

  always_comb begin
    st_d  = st_q;
    col_d = col_q;
    row_d = row_q;
    case (st_q)
      D_IDLE: if (rise) begin
        col_d = 2'd0;
        row_d = 2'd0;
        st_d  = flash_pending ? D_DRAW : D_DONE;
      end
      D_DRAW: if (col_q == 2'd2) begin
        col_d = 2'd0;
        if (row_q == 2'd2) st_d = D_DONE;
        else               row_d = row_q + 2'd1;
      end else begin
        col_d = col_q + 2'd1;
      end
      D_DONE:  st_d = D_IDLE;
      default: st_d = D_IDLE;
    endcase
  end

  // Outputs are registered from the next-state, so pixel k is on the bus while
  // the FSM sits on pixel k. Underflow wraps to >=256 and fails the bound check.
  assign px = {1'b0, centre[X_MSB:X_LSB]} + {7'd0, col_d} - 9'd1;
  assign py = {2'b0, centre[Y_MSB:0]} + {7'd0, row_d} - 9'd1;
  assign on = (st_d == D_DRAW) && (px < 9'(SCREEN_W)) && (py < 9'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q            <= D_IDLE;
      col_q           <= '0;
      row_q           <= '0;
      en_q            <= 1'b0;
      vga.vga_WriteEn <= 1'b0;
      vga.vga_coords  <= '0;
      vga.vga_colour  <= '0;
      vga.draw_done   <= 1'b0;
    end else begin
      st_q            <= st_d;
      col_q           <= col_d;
      row_q           <= row_d;
      en_q            <= vga.enable_draw;
      vga.vga_WriteEn <= on;
      vga.vga_coords  <= on ? {px[7:0], py[6:0]} : '0;
      vga.vga_colour  <= on ? FLASH_COLOUR : '0;
      vga.draw_done   <= (st_d == D_DONE);
    end
  end
endmodule

// File: rtl/laser_tower.sv
// Defensive tower: per-frame scan of four cars, cooldown-gated hits, sticky kill flags.
// Optional flash sprite drawing enabled by `define LASER_TOWER_FLASH_EN.
module laser_tower
  import laser_pkg::*;
#(
  parameter int                  TOWER_X         = 80,
  parameter int                  TOWER_Y         = 60,
  parameter int                  RANGE           = 24,
  parameter int                  HITS_TO_KILL    = 3,
  parameter int                  COOLDOWN_FRAMES = 15,
  parameter logic [COLOUR_W-1:0] FLASH_COLOUR    = 9'h1C0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               initiate,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] car_0_coords,
  input  logic [COORD_W-1:0] car_1_coords,
  input  logic [COORD_W-1:0] car_2_coords,
  input  logic [COORD_W-1:0] car_3_coords,
  output logic [3:0]         destroyed_cars,
  laser_tower_if.master      vga
);
  scan_state_e                   state_q, state_d;
  logic [1:0]                    idx_q, idx_d, tgt_q, tgt_d;
  logic                          found_q, found_d;
  logic [7:0]                    cool_q, cool_d;
  logic [3:0][2:0]               hits_q, hits_d;
  logic [3:0]                    dest_q, dest_d;
  logic                          init_q, init_rise, fire, elig;
  logic [3:0][COORD_W-1:0]       cars;
  logic [COORD_W-1:0]            cur;
  logic signed [8:0]             dx, dy;

  assign cars      = {car_3_coords, car_2_coords, car_1_coords, car_0_coords};
  assign init_rise = initiate & ~init_q;
  assign fire      = (state_q == S_FIRE);
  assign cur       = cars[idx_q];
  assign dx        = $signed({1'b0, cur[X_MSB:X_LSB]}) - $signed(9'(TOWER_X));
  assign dy        = $signed({2'b0, cur[Y_MSB:0]}) - $signed(9'(TOWER_Y));
  assign elig      = (cur != '0) && !dest_q[idx_q] &&
                     (abs9(dx) <= 9'(RANGE)) && (abs9(dy) <= 9'(RANGE));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    found_d = found_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_IDLE: if (initiate) state_d = S_WAIT;
      S_WAIT: if (frame_tick && cool_q == 8'd0) begin
        state_d = S_SCAN;
        idx_d   = 2'd0;
        found_d = 1'b0;
      end
      S_SCAN: begin
        // First eligible index sticks, so the lowest live car in range wins.
        if (elig && !found_q) begin
          found_d = 1'b1;
          tgt_d   = idx_q;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = (found_q || elig) ? S_FIRE : S_WAIT;
      end
      S_FIRE:  state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
    if (!initiate) state_d = S_IDLE;
  end

  always_comb begin
    cool_d = cool_q;
    hits_d = hits_q;
    dest_d = dest_q;
    if (frame_tick && cool_q != 8'd0) cool_d = cool_q - 8'd1;
    if (fire) begin
      cool_d         = 8'(COOLDOWN_FRAMES);
      hits_d[tgt_q]  = hits_q[tgt_q] + 3'd1;
      if (hits_q[tgt_q] + 3'd1 == 3'(HITS_TO_KILL)) dest_d[tgt_q] = 1'b1;
    end
    if (init_rise) begin
      cool_d = '0;
      hits_d = '0;
      dest_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tgt_q   <= '0;
      found_q <= 1'b0;
      cool_q  <= '0;
      hits_q  <= '0;
      dest_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      found_q <= found_d;
      cool_q  <= cool_d;
      hits_q  <= hits_d;
      dest_q  <= dest_d;
      init_q  <= initiate;
    end
  end

  assign destroyed_cars = dest_q;

`ifdef LASER_TOWER_FLASH_EN
  logic               flash_pending_q, flash_pending_d;
  logic [COORD_W-1:0] flash_xy_q, flash_xy_d;

  // A FIRE in the same cycle as draw completion keeps the new flash pending.
  always_comb begin
    flash_pending_d = flash_pending_q;
    flash_xy_d      = flash_xy_q;
    if (vga.draw_done) flash_pending_d = 1'b0;
    if (fire) begin
      flash_pending_d = 1'b1;
      flash_xy_d      = cars[tgt_q];
    end
    if (init_rise) flash_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_pending_q <= 1'b0;
      flash_xy_q      <= '0;
    end else begin
      flash_pending_q <= flash_pending_d;
      flash_xy_q      <= flash_xy_d;
    end
  end

  laser_flash_draw #(.FLASH_COLOUR(FLASH_COLOUR)) u_flash (
    .clk           (clk),
    .reset         (reset),
    .flash_pending (flash_pending_q),
    .centre        (flash_xy_q),
    .vga           (vga)
  );
`else
  logic en_q, done_q;

  // No sprite: acknowledge every draw request on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      en_q   <= vga.enable_draw;
      done_q <= vga.enable_draw & ~en_q;
    end
  end

  assign vga.draw_done   = done_q;
  assign vga.vga_WriteEn = 1'b0;
  assign vga.vga_coords  = '0;
  assign vga.vga_colour  = '0;
`endif
endmodule

// File: tb/tb_laser_tower.sv
// Self-checking bench: a centre tower for targeting/cooldown/kill flags and a
// corner tower for clipped flash drawing, with queued expectations.
module tb_laser_tower;
  import laser_pkg::*;

`ifdef LASER_TOWER_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  typedef struct {
    int                  cyc;
    logic [COORD_W-1:0]  xy;
    logic [COLOUR_W-1:0] col;
  } pix_t;

  logic               clk = 1'b0, reset = 1'b1, initiate = 1'b0, frame_tick = 1'b0;
  logic [COORD_W-1:0] car0 = '0, car1 = '0, car2 = '0, car3 = '0;
  logic [3:0]         dest_m, dest_c;
  int                 n_tests = 0, n_fail = 0;
  pix_t               pq[$];
  logic [3:0]         dq[$];

  laser_tower_if vif_m();
  laser_tower_if vif_c();

  laser_tower u_main (
    .clk(clk), .reset(reset), .initiate(initiate), .frame_tick(frame_tick),
    .car_0_coords(car0), .car_1_coords(car1), .car_2_coords(car2), .car_3_coords(car3),
    .destroyed_cars(dest_m), .vga(vif_m)
  );

  laser_tower #(.TOWER_X(0), .TOWER_Y(0), .HITS_TO_KILL(1), .COOLDOWN_FRAMES(0)) u_corner (
    .clk(clk), .reset(reset), .initiate(initiate), .frame_tick(frame_tick),
    .car_0_coords(car0), .car_1_coords(car1), .car_2_coords(car2), .car_3_coords(car3),
    .destroyed_cars(dest_c), .vga(vif_c)
  );

  always #5 clk = ~clk;

  function automatic logic [COORD_W-1:0] xy(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[7:0], yv[6:0]};
  endfunction

  // Returns just after the edge that samples the tick (cycle T).
  task automatic tick_frame();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic restart();
    @(posedge clk); #1 initiate = 1'b0;
    repeat (2) @(posedge clk);
    #1 initiate = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [33:0] obs;
    @(negedge clk);
    obs = {dest_m, dest_c, vif_m.vga_WriteEn, vif_m.vga_coords, vif_m.vga_colour, vif_m.draw_done};
    n_tests++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_kill();
    logic [3:0] e;
    car0 = xy(80, 60); car1 = '0; car2 = '0; car3 = '0;
    restart();
    for (int k = 1; k <= 36; k++) begin
      dq.push_back(k >= 33 ? 4'b0001 : 4'b0000);
      tick_frame();
      repeat (4) @(posedge clk);
      @(negedge clk);
      if (k == 33) begin
        n_tests++;
        if (dest_m !== 4'b0000) begin
          n_fail++; $display("FAIL kill_before_fire: got %b want 0000", dest_m);
        end
      end
      @(negedge clk);
      e = dq.pop_front();
      n_tests++;
      if (dest_m !== e) begin
        n_fail++; $display("FAIL kill_tick%0d: got %b want %b", k, dest_m, e);
      end
      repeat (3) @(posedge clk);
    end
    n_tests++;
    if (dest_c !== 4'b0000) begin
      n_fail++; $display("FAIL corner_out_of_range: got %b want 0000", dest_c);
    end
  endtask

  task automatic test_range();
    logic [3:0] e;
    car0 = '0; car1 = xy(110, 60); car2 = xy(90, 70); car3 = '0;
    restart();
    for (int k = 1; k <= 40; k++) begin
      dq.push_back(k >= 33 ? 4'b0100 : 4'b0000);
      tick_frame();
      repeat (4) @(posedge clk);
      @(negedge clk); @(negedge clk);
      e = dq.pop_front();
      n_tests++;
      if (dest_m !== e) begin
        n_fail++; $display("FAIL range_tick%0d: got %b want %b", k, dest_m, e);
      end
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic test_lowest_and_initiate();
    logic [3:0] e;
    car0 = xy(80, 60); car1 = xy(70, 50); car2 = '0; car3 = '0;
    restart();
    for (int k = 1; k <= 81; k++) begin
      dq.push_back(k >= 81 ? 4'b0011 : (k >= 33 ? 4'b0001 : 4'b0000));
      tick_frame();
      repeat (4) @(posedge clk);
      @(negedge clk); @(negedge clk);
      e = dq.pop_front();
      n_tests++;
      if (dest_m !== e) begin
        n_fail++; $display("FAIL lowest_tick%0d: got %b want %b", k, dest_m, e);
      end
      repeat (3) @(posedge clk);
    end
    restart();
    @(negedge clk);
    n_tests++;
    if (dest_m !== 4'b0000) begin
      n_fail++; $display("FAIL initiate_clear: got %b want 0000", dest_m);
    end
    for (int k = 1; k <= 33; k++) begin
      dq.push_back(k >= 33 ? 4'b0001 : 4'b0000);
      tick_frame();
      repeat (4) @(posedge clk);
      @(negedge clk); @(negedge clk);
      e = dq.pop_front();
      n_tests++;
      if (dest_m !== e) begin
        n_fail++; $display("FAIL restart_tick%0d: got %b want %b", k, dest_m, e);
      end
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic test_draw_clip();
    pix_t e;
    int   done_cyc, nwe, nwe_exp, x, y;
    car0 = xy(0, 1); car1 = '0; car2 = '0; car3 = '0;
    tick_frame();
    repeat (4) @(posedge clk);
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (dest_c !== 4'b0001) begin
      n_fail++; $display("FAIL corner_kill: got %b want 0001", dest_c);
    end
    repeat (3) @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      done_cyc = (FLASH && p == 0) ? 10 : 1;
      if (FLASH && p == 0)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            x = 0 + c - 1;
            y = 1 + r - 1;
            if (x >= 0 && x < 160 && y >= 0 && y < 120)
              pq.push_back('{cyc: r * 3 + c + 1, xy: xy(x, y), col: 9'h1C0});
          end
      nwe_exp = pq.size();
      nwe = 0;
      @(posedge clk); #1 vif_c.enable_draw = 1'b1;
      @(posedge clk); #1 vif_c.enable_draw = 1'b0;
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        n_tests++;
        if (vif_c.vga_WriteEn === 1'b1) begin
          nwe++;
          if (pq.size() == 0) begin
            n_fail++; $display("FAIL draw_extra_pixel: got write at cycle %0d want none", i);
          end else begin
            e = pq.pop_front();
            if (e.cyc != i || vif_c.vga_coords !== e.xy || vif_c.vga_colour !== e.col) begin
              n_fail++;
              $display("FAIL draw_pixel: got cyc %0d xy %h col %h want cyc %0d xy %h col %h",
                       i, vif_c.vga_coords, vif_c.vga_colour, e.cyc, e.xy, e.col);
            end
          end
        end else if ({vif_c.vga_coords, vif_c.vga_colour} !== '0) begin
          n_fail++;
          $display("FAIL draw_bus_idle: got xy %h col %h want 0", vif_c.vga_coords, vif_c.vga_colour);
        end
        n_tests++;
        if (vif_c.draw_done !== (i == done_cyc)) begin
          n_fail++;
          $display("FAIL draw_done p%0d cyc%0d: got %b want %b", p, i, vif_c.draw_done, (i == done_cyc));
        end
      end
      n_tests++;
      if (nwe != nwe_exp || pq.size() != 0) begin
        n_fail++; $display("FAIL draw_count p%0d: got %0d writes want %0d", p, nwe, nwe_exp);
        pq.delete();
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    logic [33:0] obs;
    @(posedge clk); #1 vif_m.enable_draw = 1'b1;
    @(posedge clk); #1 vif_m.enable_draw = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (vif_m.vga_WriteEn !== FLASH) begin
      n_fail++; $display("FAIL mid_draw_active: got %b want %b", vif_m.vga_WriteEn, FLASH);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    obs = {dest_m, dest_c, vif_m.vga_WriteEn, vif_m.vga_coords, vif_m.vga_colour, vif_m.draw_done};
    n_tests++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_mid_draw: got %h want 0", obs);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    vif_m.enable_draw = 1'b0;
    vif_c.enable_draw = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_kill();
    test_range();
    test_lowest_and_initiate();
    test_draw_clip();
    test_reset_mid_draw();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
